// File: rtl/io_uart_tx_pkg.sv
// uart_pkg: shared definitions for the io_uart_tx transmitter.
//   uart_state_e    - transmitter FSM state encoding
//   UART_DATA_BITS  - payload bits per frame (8N1)
//   UART_FRAME_BITS - total bit periods per frame (start + data + stop)
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

endpackage

// File: rtl/io_uart_tx_sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk, resetn    - clock (rising edge) and async active-low reset
//   push, din      - write request and data; ignored while full
//   pop            - read request; ignored while empty
//   dout           - head entry, valid whenever empty=0 (no read latency)
//   full, empty    - registered occupancy flags
//   count          - registered occupancy, 0..DEPTH
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok;
  logic             pop_ok;

  // Gating on the registered flags keeps count within 0..DEPTH.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset; entries are only read once written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign count = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// io_uart_tx: 8N1 UART transmitter with transmit FIFO.
//   clk, resetn - system clock (rising edge), async active-low reset
//   wr_en       - push request; wr_data is the byte to queue
//   ovf_clr     - clears the sticky overflow flag (a same-cycle drop wins)
//   full, empty - FIFO occupancy flags; count is the occupancy
//   overflow    - sticky: a push arrived while full and was dropped
//   busy        - a frame is on the line
//   tx          - serial output, idle high, LSB first
module io_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  input  logic             ovf_clr,
  output logic             full,
  output logic             empty,
  output logic             busy,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             tx
);

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BIT_LAST  = 3'(UART_DATA_BITS - 1);

  uart_state_e state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        overflow_q, overflow_d;

  logic        pop;
  logic        bit_end;
  logic [7:0]  fifo_dout;
  logic        fifo_full;
  logic        fifo_empty;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (wr_en),
    .pop    (pop),
    .din    (wr_data),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (count)
  );

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    // The line level follows the current state, so tx lags each state
    // change by one cycle; every bit period still spans CLKS_PER_BIT.
    case (state_q)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      default: tx_d = 1'b1;
    endcase

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_d = '0;
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);

    if (wr_en && fifo_full) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign full     = fifo_full;
  assign empty    = fifo_empty;
  assign busy     = busy_q;
  assign overflow = overflow_q;
  assign tx       = tx_q;

endmodule

// File: tb/tb_io_uart_tx.sv
module tb_io_uart_tx;

  logic       clk = 1'b0;
  logic       resetn;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Small build: CLKS_PER_BIT=4, FIFO_DEPTH=4
  logic       wr_en, ovf_clr;
  logic [7:0] wr_data;
  logic       full, empty, busy, overflow, tx;
  logic [2:0] count;

  // Default build: CLKS_PER_BIT=434, FIFO_DEPTH=16
  logic       b_wr_en, b_ovf_clr;
  logic [7:0] b_wr_data;
  logic       b_full, b_empty, b_busy, b_overflow, b_tx;
  logic [4:0] b_count;

  io_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_data(wr_data),
    .ovf_clr(ovf_clr), .full(full), .empty(empty), .busy(busy),
    .count(count), .overflow(overflow), .tx(tx)
  );

  io_uart_tx dut_big (
    .clk(clk), .resetn(resetn), .wr_en(b_wr_en), .wr_data(b_wr_data),
    .ovf_clr(b_ovf_clr), .full(b_full), .empty(b_empty), .busy(b_busy),
    .count(b_count), .overflow(b_overflow), .tx(b_tx)
  );

  int passed = 0;
  int total  = 0;

  // Frames decoded from the small build's tx line
  logic [7:0] rx_data [$];
  logic       rx_stop [$];
  int         rx_t    [$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    step(1);
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (!busy && empty) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  task automatic clear_rx();
    rx_data.delete();
    rx_stop.delete();
    rx_t.delete();
  endtask

  // Independent receiver: finds a falling edge, samples mid-bit.
  initial begin : decoder
    logic       prev;
    logic [7:0] d;
    int         s;
    prev = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (prev === 1'b1 && tx === 1'b0) begin
        s = cyc;
        step(2);
        if (tx === 1'b0) begin
          for (int k = 0; k < 8; k++) begin
            step(4);
            d[k] = tx;
          end
          step(4);
          rx_data.push_back(d);
          rx_stop.push_back(tx);
          rx_t.push_back(s);
        end
      end
      prev = tx;
    end
  end

  task automatic test_reset();
    resetn = 1'b0;
    wr_en = 1'b0; wr_data = '0; ovf_clr = 1'b0;
    b_wr_en = 1'b0; b_wr_data = '0; b_ovf_clr = 1'b0;
    step(3);
    total++; if (tx !== 1'b1)       $display("FAIL reset_tx got %b exp 1", tx); else passed++;
    total++; if (busy !== 1'b0)     $display("FAIL reset_busy got %b exp 0", busy); else passed++;
    total++; if (full !== 1'b0)     $display("FAIL reset_full got %b exp 0", full); else passed++;
    total++; if (empty !== 1'b1)    $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    total++; if (count !== 3'd0)    $display("FAIL reset_count got %0d exp 0", count); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %b exp 0", overflow); else passed++;
    total++; if (b_tx !== 1'b1)     $display("FAIL reset_big_tx got %b exp 1", b_tx); else passed++;
    resetn = 1'b1;
    step(3);
    total++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL reset_release tx=%b busy=%b exp 1/0", tx, busy); else passed++;
    clear_rx();
  endtask

  task automatic test_single_byte();
    logic [7:0] exp;
    int n;
    bit ok;
    exp = 8'b1010_0101;
    push_byte(8'hA5);
    n = cyc;
    total++; if (empty !== 1'b0 || count !== 3'd1) $display("FAIL single_push empty=%b count=%0d exp 0/1", empty, count); else passed++;
    total++; if (tx !== 1'b1 || busy !== 1'b0) $display("FAIL single_edgeN tx=%b busy=%b exp 1/0", tx, busy); else passed++;
    step(1);
    total++; if (busy !== 1'b1 || empty !== 1'b1 || tx !== 1'b1) $display("FAIL single_pop busy=%b empty=%b tx=%b exp 1/1/1", busy, empty, tx); else passed++;
    step(1);
    total++; if (tx !== 1'b0) $display("FAIL single_start tx=%b exp 0", tx); else passed++;
    step(6);
    for (int k = 0; k < 8; k++) begin
      total++; if (tx !== exp[k]) $display("FAIL single_bit%0d tx=%b exp %b", k, tx, exp[k]); else passed++;
      step(4);
    end
    total++; if (tx !== 1'b1 || busy !== 1'b1) $display("FAIL single_stop tx=%b busy=%b exp 1/1", tx, busy); else passed++;
    step(1);
    total++; if (busy !== 1'b0 || cyc - n !== 41) $display("FAIL single_busy_fall busy=%b at +%0d exp 0 at +41", busy, cyc - n); else passed++;
    wait_idle(20, ok);
    total++; if (!ok || rx_data.size() != 1) $display("FAIL single_frames got %0d exp 1", rx_data.size()); else passed++;
    if (rx_data.size() == 1) begin
      total++; if (rx_data[0] !== 8'hA5 || rx_stop[0] !== 1'b1) $display("FAIL single_rx got %h/%b exp a5/1", rx_data[0], rx_stop[0]); else passed++;
      total++; if (rx_t[0] - n != 2) $display("FAIL single_latency got %0d exp 2", rx_t[0] - n); else passed++;
    end
    clear_rx();
  endtask

  task automatic test_back_to_back();
    int bc;
    bit ok;
    wr_en = 1'b1; wr_data = 8'h00; step(1);
    wr_data = 8'hFF; step(1);
    wr_en = 1'b0;
    total++; if (count !== 3'd1) $display("FAIL b2b_count got %0d exp 1", count); else passed++;
    bc = 0;
    for (int i = 0; i < 200; i++) begin
      if (!busy) break;
      bc++;
      step(1);
    end
    total++; if (bc != 80) $display("FAIL b2b_busy_cycles got %0d exp 80", bc); else passed++;
    wait_idle(20, ok);
    total++; if (!ok || rx_data.size() != 2) $display("FAIL b2b_frames got %0d exp 2", rx_data.size()); else passed++;
    if (rx_data.size() == 2) begin
      total++; if (rx_data[0] !== 8'h00 || rx_data[1] !== 8'hFF) $display("FAIL b2b_data got %h %h exp 00 ff", rx_data[0], rx_data[1]); else passed++;
      total++; if (rx_t[1] - rx_t[0] != 40) $display("FAIL b2b_gap got %0d exp 40", rx_t[1] - rx_t[0]); else passed++;
      total++; if (rx_stop[0] !== 1'b1 || rx_stop[1] !== 1'b1) $display("FAIL b2b_stop got %b %b exp 1 1", rx_stop[0], rx_stop[1]); else passed++;
    end
    clear_rx();
  endtask

  task automatic test_overflow();
    logic [7:0] q [5];
    bit ok;
    q[0] = 8'h11; q[1] = 8'h22; q[2] = 8'h33; q[3] = 8'h44; q[4] = 8'h55;
    push_byte(q[0]);
    step(1);
    wr_en = 1'b1;
    for (int i = 1; i < 5; i++) begin
      wr_data = q[i];
      step(1);
    end
    wr_en = 1'b0;
    total++; if (count !== 3'd4 || full !== 1'b1) $display("FAIL ovf_fill count=%0d full=%b exp 4/1", count, full); else passed++;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_before got %b exp 0", overflow); else passed++;
    push_byte(8'h66);
    total++; if (overflow !== 1'b1 || count !== 3'd4) $display("FAIL ovf_drop overflow=%b count=%0d exp 1/4", overflow, count); else passed++;
    wr_en = 1'b1; wr_data = 8'h77; ovf_clr = 1'b1;
    step(1);
    wr_en = 1'b0;
    total++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins got %b exp 1", overflow); else passed++;
    step(1);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b0) $display("FAIL ovf_clr got %b exp 0", overflow); else passed++;
    wait_idle(400, ok);
    total++; if (!ok || rx_data.size() != 5) $display("FAIL ovf_frames got %0d exp 5", rx_data.size()); else passed++;
    if (rx_data.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        total++; if (rx_data[i] !== q[i]) $display("FAIL ovf_order%0d got %h exp %h", i, rx_data[i], q[i]); else passed++;
      end
    end
    total++; if (count !== 3'd0 || empty !== 1'b1) $display("FAIL ovf_drain count=%0d empty=%b exp 0/1", count, empty); else passed++;
    clear_rx();
  endtask

  task automatic test_push_on_pop();
    logic [7:0] q [4];
    bit ok;
    q[0] = 8'hC3; q[1] = 8'h5A; q[2] = 8'h96; q[3] = 8'h3E;
    push_byte(q[0]);
    step(1);
    push_byte(q[1]);
    push_byte(q[2]);
    step(37);
    total++; if (count !== 3'd2) $display("FAIL pop_pre_count got %0d exp 2", count); else passed++;
    push_byte(q[3]);
    total++; if (count !== 3'd2 || tx !== 1'b1) $display("FAIL pop_same_cycle count=%0d tx=%b exp 2/1", count, tx); else passed++;
    step(1);
    total++; if (tx !== 1'b0) $display("FAIL pop_next_start tx=%b exp 0", tx); else passed++;
    wait_idle(300, ok);
    total++; if (!ok || rx_data.size() != 4) $display("FAIL pop_frames got %0d exp 4", rx_data.size()); else passed++;
    if (rx_data.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        total++; if (rx_data[i] !== q[i]) $display("FAIL pop_order%0d got %h exp %h", i, rx_data[i], q[i]); else passed++;
      end
    end
    clear_rx();
  endtask

  task automatic test_reset_mid_frame();
    int lows;
    int busies;
    bit ok;
    push_byte(8'h3C);
    push_byte(8'h99);
    step(17);
    total++; if (busy !== 1'b1 || count !== 3'd1) $display("FAIL rst_pre busy=%b count=%0d exp 1/1", busy, count); else passed++;
    #2 resetn = 1'b0;
    #1;
    total++; if (tx !== 1'b1 || busy !== 1'b0 || count !== 3'd0) $display("FAIL rst_async tx=%b busy=%b count=%0d exp 1/0/0", tx, busy, count); else passed++;
    step(2);
    resetn = 1'b1;
    lows = 0; busies = 0;
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busies++;
    end
    total++; if (lows != 0 || busies != 0) $display("FAIL rst_idle low=%0d busy=%0d exp 0/0", lows, busies); else passed++;
    clear_rx();
    push_byte(8'h81);
    step(2);
    wait_idle(100, ok);
    total++; if (!ok || rx_data.size() != 1) $display("FAIL rst_frames got %0d exp 1", rx_data.size()); else passed++;
    if (rx_data.size() == 1) begin
      total++; if (rx_data[0] !== 8'h81 || rx_stop[0] !== 1'b1) $display("FAIL rst_rx got %h/%b exp 81/1", rx_data[0], rx_stop[0]); else passed++;
    end
    clear_rx();
  endtask

  task automatic test_default_baud();
    int n, bc, ntr, bad;
    int tr [12];
    logic prev;
    b_wr_en = 1'b1; b_wr_data = 8'h55;
    step(1);
    b_wr_en = 1'b0;
    n = cyc;
    prev = b_tx;
    bc = 0; ntr = 0;
    for (int i = 0; i < 5000; i++) begin
      step(1);
      if (b_busy) bc++;
      if (b_tx !== prev) begin
        if (ntr < 12) tr[ntr] = cyc;
        ntr++;
        prev = b_tx;
      end
      if (!b_busy && bc > 0) break;
    end
    total++; if (bc != 4340) $display("FAIL baud_frame_len got %0d exp 4340", bc); else passed++;
    total++; if (ntr != 10) $display("FAIL baud_transitions got %0d exp 10", ntr); else passed++;
    if (ntr == 10) begin
      total++; if (tr[0] - n != 2) $display("FAIL baud_latency got %0d exp 2", tr[0] - n); else passed++;
      bad = 0;
      for (int k = 1; k < 10; k++) if (tr[k] - tr[k-1] != 434) bad++;
      total++; if (bad != 0) $display("FAIL baud_period bad_intervals=%0d exp 0", bad); else passed++;
    end
    total++; if (b_tx !== 1'b1 || b_empty !== 1'b1) $display("FAIL baud_end tx=%b empty=%b exp 1/1", b_tx, b_empty); else passed++;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_overflow();
    test_push_on_pop();
    test_reset_mid_frame();
    test_default_baud();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
